// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I-cache/D-cache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    // One cache's request bundle as seen by the arbiter.
    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BLK_W-1:0]  wdata;
    } cache_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, grant the requester that was not served last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        gnt_id = REQ_IC;
        any    = |req;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = REQ_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between the I-cache and D-cache with round-robin
// fairness and a one-cycle RELEASE gap after every completed transaction.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [BLK_W-1:0]  ic_wdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [BLK_W-1:0]  dc_wdata,
    output logic              dc_ready,
    output logic [BLK_W-1:0]  rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    arb_state_t state, state_next;
    logic       owner, owner_next;
    logic       last, last_next;

    cache_req_t ic_req, dc_req, own_req;
    logic [1:0] pending;
    logic       pick_id;
    logic       pick_any;
    logic       own_pending;

    assign ic_req      = {ic_read, ic_write, ic_addr, ic_wdata};
    assign dc_req      = {dc_read, dc_write, dc_addr, dc_wdata};
    assign pending     = {dc_req.read | dc_req.write, ic_req.read | ic_req.write};
    assign own_req     = (owner == REQ_DC) ? dc_req : ic_req;
    assign own_pending = own_req.read | own_req.write;
    assign rdata       = mem_rdata;

    rr_pick2 u_pick (
        .req    (pending),
        .last   (last),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // State, owner and last-served registers.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state <= IDLE;
            owner <= REQ_IC;
            last  <= REQ_DC;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
        end
    end

    // Next state: grant from IDLE, finish or abandon in BUSY, single-cycle RELEASE.
    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                    owner_next = pick_id;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next = RELEASE;
                    last_next  = owner;
                end else if (!own_pending) begin
                    state_next = IDLE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side mux and ready steering; everything is quiet outside BUSY.
    always_comb begin
        busy      = (state == BUSY);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ready  = 1'b0;
        dc_ready  = 1'b0;
        if (busy) begin
            mem_write = own_req.write;
            mem_read  = own_req.read & ~own_req.write;
            mem_addr  = own_req.addr;
            mem_wdata = own_req.wdata;
            ic_ready  = mem_ready & (owner == REQ_IC);
            dc_ready  = mem_ready & (owner == REQ_DC);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of who holds the memory port.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk;
    logic              proc_reset_n;
    logic              ic_read, ic_write, dc_read, dc_write;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [BLK_W-1:0]  ic_wdata, dc_wdata;
    logic              ic_ready, dc_ready;
    logic [BLK_W-1:0]  rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Model: m_gnt = requester holding the port (-1 none), m_rel = in the post-completion gap.
    int m_gnt  = -1;
    int m_last = 1;
    bit m_rel  = 1'b0;

    logic              e_read, e_write, e_busy, e_ic_ready, e_dc_ready;
    logic [ADDR_W-1:0] e_addr;
    logic [BLK_W-1:0]  e_wdata;

    mem_arbiter dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .ic_read      (ic_read),
        .ic_write     (ic_write),
        .ic_addr      (ic_addr),
        .ic_wdata     (ic_wdata),
        .ic_ready     (ic_ready),
        .dc_read      (dc_read),
        .dc_write     (dc_write),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_ready     (dc_ready),
        .rdata        (rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit pend(input int who);
        return (who == 0) ? (ic_read | ic_write) : (dc_read | dc_write);
    endfunction

    task automatic model_advance();
        if (!proc_reset_n) begin
            m_gnt = -1; m_rel = 1'b0; m_last = 1;
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_gnt < 0) begin
            if (pend(0) && pend(1)) m_gnt = 1 - m_last;
            else if (pend(0))      m_gnt = 0;
            else if (pend(1))      m_gnt = 1;
        end else if (mem_ready) begin
            m_last = m_gnt; m_gnt = -1; m_rel = 1'b1;
        end else if (!pend(m_gnt)) begin
            m_gnt = -1;
        end
    endtask

    task automatic eval_expected();
        e_busy = (m_gnt >= 0);
        e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
        e_ic_ready = 1'b0; e_dc_ready = 1'b0;
        if (m_gnt == 0) begin
            e_write = ic_write; e_read = ic_read && !ic_write;
            e_addr = ic_addr; e_wdata = ic_wdata; e_ic_ready = mem_ready;
        end else if (m_gnt == 1) begin
            e_write = dc_write; e_read = dc_read && !dc_write;
            e_addr = dc_addr; e_wdata = dc_wdata; e_dc_ready = mem_ready;
        end
    endtask

    // Advance one clock: the model consumes the inputs sampled at the edge.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive_idle();
        ic_read = 0; ic_write = 0; ic_addr = '0; ic_wdata = '0;
        dc_read = 0; dc_write = 0; dc_addr = '0; dc_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        proc_reset_n = 0;
        tick(); tick();
        proc_reset_n = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'(i % 2);   // stray mem_ready while idle must be ignored
            #3;
            checks++;
            if ({mem_read, mem_write, busy, ic_ready, dc_ready} !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got rd/wr/busy/icr/dcr=%b want 00000", i,
                         {mem_read, mem_write, busy, ic_ready, dc_ready});
            end
            tick();
        end
        mem_ready = 0;
    endtask

    task automatic test_single_ic_read();
        logic [BLK_W-1:0] pat;
        pat = {16{8'hA5}};
        ic_read = 1; ic_addr = 28'h0000123;
        #3;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ic_rd_T busy: got %b want 0", busy); end
        tick();
        for (int k = 1; k <= 4; k++) begin
            #3;
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 28'h0000123 || ic_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ic_rd_wait T+%0d: got rd=%b addr=%h icr=%b busy=%b want 1 0000123 0 1",
                         k, mem_read, mem_addr, ic_ready, busy);
            end
            tick();
        end
        mem_ready = 1; mem_rdata = pat;
        #3;
        checks++;
        if (ic_ready !== 1'b1 || dc_ready !== 1'b0 || rdata !== pat) begin
            errors++;
            $display("FAIL ic_rd_done: got icr=%b dcr=%b rdata=%h want 1 0 %h", ic_ready, dc_ready, rdata, pat);
        end
        tick();
        ic_read = 0; mem_ready = 0;
        for (int k = 6; k <= 7; k++) begin
            #3;
            checks++;
            if (busy !== 1'b0 || mem_read !== 1'b0 || ic_ready !== 1'b0) begin
                errors++;
                $display("FAIL ic_rd_after T+%0d: got busy=%b rd=%b icr=%b want 0 0 0", k, busy, mem_read, ic_ready);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        logic [BLK_W-1:0] wd;
        wd = {16{8'h55}};
        drive_idle();
        do_reset();
        ic_read = 1; ic_addr = 28'h10;
        dc_write = 1; dc_addr = 28'h20; dc_wdata = wd;
        tick();
        #3;
        checks++;
        if (busy !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h10) begin
            errors++;
            $display("FAIL simul_ic_first: got busy=%b rd=%b wr=%b addr=%h want 1 1 0 10", busy, mem_read, mem_write, mem_addr);
        end
        tick();
        mem_ready = 1;
        #3;
        checks++;
        if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_ic_ready: got icr=%b dcr=%b want 1 0", ic_ready, dc_ready);
        end
        tick();
        ic_read = 0; mem_ready = 0;
        tick();   // RELEASE
        tick();   // IDLE, DC pending
        #3;
        checks++;
        if (busy !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h20 || mem_wdata !== wd) begin
            errors++;
            $display("FAIL simul_dc_grant: got busy=%b wr=%b rd=%b addr=%h wdata=%h want 1 1 0 20 %h",
                     busy, mem_write, mem_read, mem_addr, mem_wdata, wd);
        end
        tick();
        mem_ready = 1;
        #3;
        checks++;
        if (dc_ready !== 1'b1 || ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_dc_ready: got dcr=%b icr=%b want 1 0", dc_ready, ic_ready);
        end
        tick();
        drive_idle();
        tick(); tick();
    endtask

    task automatic test_fairness();
        int  grants;
        int  gseq [8];
        bit  prev_busy;
        drive_idle();
        do_reset();
        ic_read = 1; ic_addr = 28'h100;
        dc_read = 1; dc_addr = 28'h200;
        grants = 0; prev_busy = 0;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            mem_ready = prev_busy && !mem_ready;
            #3;
            if (busy && !prev_busy) begin
                gseq[grants] = (mem_addr == 28'h100) ? 0 : (mem_addr == 28'h200) ? 1 : 2;
                grants++;
            end
            checks++;
            if ((mem_addr == 28'h100 && dc_ready) || (mem_addr == 28'h200 && ic_ready) || (!busy && (ic_ready || dc_ready))) begin
                errors++;
                $display("FAIL fair_nonowner_ready cyc %0d: got addr=%h icr=%b dcr=%b want no ready to non-owner",
                         c, mem_addr, ic_ready, dc_ready);
            end
            prev_busy = busy;
            tick();
        end
        checks++;
        if (grants != 8) begin
            errors++;
            $display("FAIL fair_timeout: got %0d grants want 8", grants);
        end
        for (int i = 0; i < grants; i++) begin
            checks++;
            if (gseq[i] != i % 2) begin
                errors++;
                $display("FAIL fair_order grant %0d: got owner %0d want %0d", i, gseq[i], i % 2);
            end
        end
        drive_idle();
        tick(); tick(); tick();
    endtask

    task automatic test_writeback_allocate();
        logic [BLK_W-1:0] wd, rd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        rd = {$urandom, $urandom, $urandom, $urandom};
        drive_idle();
        dc_write = 1; dc_addr = 28'h40; dc_wdata = wd;
        tick();
        #3;
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 28'h40 || mem_wdata !== wd) begin
            errors++;
            $display("FAIL wb_write: got wr=%b addr=%h wdata=%h want 1 40 %h", mem_write, mem_addr, mem_wdata, wd);
        end
        tick();
        mem_ready = 1;
        #3;
        checks++;
        if (dc_ready !== 1'b1) begin errors++; $display("FAIL wb_ready: got %b want 1", dc_ready); end
        tick();
        dc_write = 0; dc_read = 1; dc_addr = 28'h08; mem_ready = 0;   // re-request in RELEASE
        #3;
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL wb_release: got busy=%b rd=%b want 0 0", busy, mem_read);
        end
        tick();
        #3;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wb_idle: got busy=%b want 0", busy); end
        tick();
        #3;
        checks++;
        if (busy !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h08) begin
            errors++;
            $display("FAIL alloc_read: got busy=%b rd=%b wr=%b addr=%h want 1 1 0 08", busy, mem_read, mem_write, mem_addr);
        end
        tick();
        mem_ready = 1; mem_rdata = rd;
        #3;
        checks++;
        if (dc_ready !== 1'b1 || rdata !== rd) begin
            errors++;
            $display("FAIL alloc_done: got dcr=%b rdata=%h want 1 %h", dc_ready, rdata, rd);
        end
        tick();
        drive_idle();
        tick(); tick();
    endtask

    task automatic test_reset_mid_busy();
        drive_idle();
        dc_read = 1; dc_addr = 28'h77;
        tick();
        tick();
        proc_reset_n = 0;
        tick();
        proc_reset_n = 1; mem_ready = 1;
        #3;
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || dc_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: got busy=%b rd=%b dcr=%b want 0 0 0", busy, mem_read, dc_ready);
        end
        tick();
        drive_idle();
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            proc_reset_n = ($urandom_range(0, 127) != 0);
            if ($urandom_range(0, 3) == 0) begin
                ic_read = 1'($urandom_range(0, 1)); ic_write = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                dc_read = 1'($urandom_range(0, 1)); dc_write = ($urandom_range(0, 3) == 0);
            end
            ic_addr = ADDR_W'($urandom); dc_addr = ADDR_W'($urandom);
            ic_wdata = {$urandom, $urandom, $urandom, $urandom};
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #3;
            eval_expected();
            checks++;
            if ({mem_read, mem_write, busy, ic_ready, dc_ready} !== {e_read, e_write, e_busy, e_ic_ready, e_dc_ready}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got rd/wr/busy/icr/dcr=%b want %b", c,
                         {mem_read, mem_write, busy, ic_ready, dc_ready}, {e_read, e_write, e_busy, e_ic_ready, e_dc_ready});
            end
            checks++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_data cyc %0d: got addr=%h wdata=%h want %h %h", c, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            checks++;
            if (rdata !== mem_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc %0d: got %h want %h", c, rdata, mem_rdata);
            end
            tick();
        end
        proc_reset_n = 1;
        drive_idle();
        tick(); tick(); tick();
    endtask

    initial begin
        proc_reset_n = 0;
        drive_idle();
        #1;
        test_reset();
        test_single_ic_read();
        test_simultaneous();
        test_fairness();
        test_writeback_allocate();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
